// File: rtl/tbird_pkg.sv
// tbird_pkg -- shared types and defaults for the turn-signal switch front end.
//
// Contents:
//   deb_state_t          2-bit debouncer FSM state
//   DEBOUNCE_CYCLES_DEF  default number of confirming samples (beyond the first)
//   SYNC_STAGES_DEF      default input synchronizer depth
package tbird_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } deb_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sw_debounce_chan.sv
// sw_debounce_chan -- one switch channel: synchronizer, debounce FSM, counter.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   raw    asynchronous bouncing contact
//   level  debounced level (registered state decode, no path from raw)
//   rise   one-cycle pulse on an accepted 0->1 change
//
// Macro SW_DEBOUNCE_RISE_EN: when defined, rise is generated; otherwise it is
// tied low and no edge-detect flop exists.
module sw_debounce_chan
    import tbird_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    deb_state_t             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter defaults to 0, so it is cleared on every exit from a WAIT state
    // and held at 0 in both STABLE states; it only advances while confirming.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            STABLE_LO: if (s) state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (!s)                  state_nxt = STABLE_LO;
                else if (cnt == CNT_LAST) state_nxt = STABLE_HI;
                else                     cnt_nxt   = cnt + 1'b1;
            end
            STABLE_HI: if (!s) state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (s)                   state_nxt = STABLE_HI;
                else if (cnt == CNT_LAST) state_nxt = STABLE_LO;
                else                     cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = STABLE_LO;
        endcase
    end

    assign level = (state == STABLE_HI) || (state == WAIT_LO);

`ifdef SW_DEBOUNCE_RISE_EN
    // Registered from the acceptance transition so the pulse lines up with
    // the first cycle level reads 1.
    logic rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) rise_q <= 1'b0;
        else        rise_q <= (state == WAIT_HI) && (state_nxt == STABLE_HI);
    end

    assign rise = rise_q;
`else
    assign rise = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce -- three independent debounced switch channels.
//
// Ports:
//   CLK      rising-edge clock
//   RST_N    synchronous active-low reset
//   SW_RAW   [2:0] asynchronous bouncing contacts, bit i -> channel i
//   SW0..SW2 debounced levels of channels 0..2
//   SW_RISE  [2:0] one-cycle accepted-rise pulse per channel
//
// Macro SW_DEBOUNCE_RISE_EN enables SW_RISE; without it SW_RISE reads 3'b000.
module sw_debounce
    import tbird_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] SW_RAW,
    output logic       SW0,
    output logic       SW1,
    output logic       SW2,
    output logic [2:0] SW_RISE
);

    sw_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan0 (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (SW_RAW[0]),
        .level (SW0),
        .rise  (SW_RISE[0])
    );

    sw_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan1 (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (SW_RAW[1]),
        .level (SW1),
        .rise  (SW_RISE[1])
    );

    sw_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan2 (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (SW_RAW[2]),
        .level (SW2),
        .rise  (SW_RISE[2])
    );

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive synchronized samples (beyond the first) required to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the input synchronizer; legal range 2..4.
REQ-003 SHALL have port CLK  input  1  the single rising-edge clock.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low, sampled on the CLK rising edge.
REQ-005 SHALL have port SW_RAW  input  3  asynchronous, bouncing switch contacts; bit i feeds channel i.
REQ-006 SHALL have ports SW0, SW1, SW2  output  1 each  debounced levels of channels 0..2, directly drivable into the turn-signal controller switch inputs.
REQ-007 SHALL have port SW_RISE  output  3  one-cycle pulse per channel on an accepted 0->1 change.

Function
REQ-008 Each channel SHALL pass SW_RAW[i] through SYNC_STAGES flip-flops; the last stage is the synchronized value s.
REQ-009 Each channel SHALL run a four-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, with a counter at least $clog2(DEBOUNCE_CYCLES) bits wide.
REQ-010 In STABLE_LO with s=1, the FSM SHALL go to WAIT_HI and clear the counter; with s=0, it SHALL stay in STABLE_LO.
REQ-011 In WAIT_HI with s=0, the FSM SHALL return to STABLE_LO, clear the counter and leave the output unchanged (bounce rejected).
REQ-012 In WAIT_HI with s=1 and counter=DEBOUNCE_CYCLES-1, the FSM SHALL go to STABLE_HI and set the output to 1; otherwise the counter SHALL increment.
REQ-013 STABLE_HI and WAIT_LO SHALL mirror REQ-010..012 with polarity inverted.
REQ-014 Output SWi SHALL be 1 exactly in STABLE_HI and WAIT_LO, registered, with no combinational path from SW_RAW.
REQ-015 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges from the first edge sampling a clean stable raw change to the output change.
REQ-016 A raw pulse shorter than DEBOUNCE_CYCLES+1 synchronized samples SHALL never change the output.
REQ-017 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each complete with the same latency.
REQ-018 The counter SHALL never wrap; it SHALL be bounded by DEBOUNCE_CYCLES-1 in WAIT states and held at 0 in STABLE states.

Reset
REQ-019 While RST_N=0 at a CLK edge: synchronizer flops=0, FSM=STABLE_LO, counter=0, SW0/SW1/SW2=0, SW_RISE=0.
REQ-020 Reset asserted mid-WAIT SHALL abort the pending change; after release, a raw level held at 1 SHALL be re-debounced from scratch (full REQ-015 latency).

Configuration
REQ-021 With macro SW_DEBOUNCE_RISE_EN defined, SW_RISE[i] SHALL pulse high for exactly one cycle, coincident with the first cycle SWi reads 1 after WAIT_HI->STABLE_HI.
REQ-022 Without SW_DEBOUNCE_RISE_EN, SW_RISE SHALL be tied to 3'b000, the port SHALL remain present, and no edge-detect logic SHALL be synthesized.

Structure
REQ-023 The FSM state typedef (2-bit encoding) and the default constants for DEBOUNCE_CYCLES and SYNC_STAGES SHALL live in shared package tbird_pkg.
REQ-024 Per-channel logic (synchronizer, FSM, counter) SHALL be sub-module sw_debounce_chan, instantiated three times; the top SHALL contain only instances and output mapping.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless noted)
REQ-025 Reset with SW_RAW=3'b111 held, RST_N released at edge 0 -> SW0..SW2 rise at edge 6, and not before.
REQ-026 SW_RAW[1] 0->1, held clean -> SW1=1 exactly 6 edges later; SW_RISE[1] pulses one cycle with macro defined, stays 0 without it.
REQ-027 SW_RAW[0] high for 4 cycles then low -> SW0 stays 0 throughout; a 5-cycle pulse -> SW0 goes high.
REQ-028 SW_RAW[2] toggles every 2 cycles for 40 cycles, then holds 1 -> SW2 stays 0 during toggling and goes 1 exactly 6 edges after the hold begins.
REQ-029 SW_RAW=3'b101 applied simultaneously -> SW0 and SW2 rise on the same edge; SW1 stays 0.
REQ-030 RST_N pulsed low during WAIT_HI of channel 1 (raw held 1) -> SW1=0 during reset; SW1=1 exactly 6 edges after release.
